// File: rtl/issue_multi_select.sv
// issue_multi_select
// Picks up to NUM_GRANTS ready entries per cycle out of SIZE requesters and
// presents them as registered grant slots, in the order they were found.
// Entries granted in the previous cycle are masked off so a request that is
// still high is not granted twice in a row.
//
// Configuration macro: ISSUE_MULTI_SELECT_RR_EN
//   defined   : scan starts at a rotating pointer that moves to one past the
//               last granted entry after every selection cycle with a grant.
//   undefined : no pointer register; scan always starts at entry 0
//               (lowest index wins).
//
// Handshake: i_stall=1 means downstream cannot take the current slots, so
// outputs and the pointer freeze and no selection happens. i_flush=1 empties
// all slots on the next edge and overrides i_stall; the pointer is kept.
module issue_multi_select #(
    parameter  int SIZE       = 16,
    parameter  int NUM_GRANTS = 2,
    localparam int IW         = $clog2(SIZE),
    localparam int CW         = $clog2(NUM_GRANTS + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_flush,
    input  logic          i_stall,
    input  logic          i_req_mask   [SIZE],
    output logic          o_valid      [NUM_GRANTS],
    output logic [IW-1:0] o_idx        [NUM_GRANTS],
    output logic [SIZE-1:0] o_grant_mask,
    output logic [CW-1:0] o_count
);

    logic [SIZE-1:0] eligible;
    logic            nxt_valid [NUM_GRANTS];
    logic [IW-1:0]   nxt_idx   [NUM_GRANTS];
    logic [SIZE-1:0] nxt_mask;
    logic [CW-1:0]   nxt_count;
    logic [IW-1:0]   scan_pos;

`ifdef ISSUE_MULTI_SELECT_RR_EN
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   nxt_last;
`else
    localparam logic [IW-1:0] ptr = '0;
`endif

    // Entries still holding a grant from last cycle are not eligible again.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < SIZE; i++) begin
            eligible[i] = i_req_mask[i] & ~o_grant_mask[i];
        end
    end

    // Priority scan from ptr, wrapping; the k-th hit lands in slot k.
    always_comb begin
        for (int g = 0; g < NUM_GRANTS; g++) begin
            nxt_valid[g] = 1'b0;
            nxt_idx[g]   = '0;
        end
        nxt_mask  = '0;
        nxt_count = '0;
        scan_pos  = '0;
`ifdef ISSUE_MULTI_SELECT_RR_EN
        nxt_last  = '0;
`endif
        for (int j = 0; j < SIZE; j++) begin
            // IW-bit addition wraps modulo SIZE because SIZE is a power of 2.
            scan_pos = ptr + IW'(j);
            if (eligible[scan_pos] && (nxt_count < CW'(NUM_GRANTS))) begin
                for (int g = 0; g < NUM_GRANTS; g++) begin
                    if (nxt_count == CW'(g)) begin
                        nxt_valid[g] = 1'b1;
                        nxt_idx[g]   = scan_pos;
                    end
                end
                nxt_mask[scan_pos] = 1'b1;
`ifdef ISSUE_MULTI_SELECT_RR_EN
                nxt_last = scan_pos;
`endif
                nxt_count = nxt_count + CW'(1);
            end
        end
    end

    // Grant slot registers: reset/flush clear, stall holds, otherwise load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int g = 0; g < NUM_GRANTS; g++) begin
                o_valid[g] <= 1'b0;
                o_idx[g]   <= '0;
            end
            o_grant_mask <= '0;
            o_count      <= '0;
        end else if (i_flush) begin
            for (int g = 0; g < NUM_GRANTS; g++) begin
                o_valid[g] <= 1'b0;
                o_idx[g]   <= '0;
            end
            o_grant_mask <= '0;
            o_count      <= '0;
        end else if (!i_stall) begin
            for (int g = 0; g < NUM_GRANTS; g++) begin
                o_valid[g] <= nxt_valid[g];
                o_idx[g]   <= nxt_idx[g];
            end
            o_grant_mask <= nxt_mask;
            o_count      <= nxt_count;
        end
    end

`ifdef ISSUE_MULTI_SELECT_RR_EN
    // Rotating pointer: advances past the last grant, held on flush/stall/no grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (!i_flush && !i_stall && (|nxt_mask)) begin
            ptr <= nxt_last + IW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_issue_multi_select.sv
// Directed bench for issue_multi_select: a 16x2 instance carries most of the
// sequence and a 16x4 instance covers the four-slot wrap case. Expected values
// are hand-computed for both the rotating and the fixed-priority build.
module tb_issue_multi_select;

`ifdef ISSUE_MULTI_SELECT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        stall;

    logic        req1 [16];
    logic        v1   [2];
    logic [3:0]  idx1 [2];
    logic [15:0] gm1;
    logic [1:0]  cnt1;

    logic        req2 [16];
    logic        v2   [4];
    logic [3:0]  idx2 [4];
    logic [15:0] gm2;
    logic [2:0]  cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    issue_multi_select #(.SIZE(16), .NUM_GRANTS(2)) dut1 (
        .clk(clk), .rstn(rstn), .i_flush(flush), .i_stall(stall),
        .i_req_mask(req1), .o_valid(v1), .o_idx(idx1),
        .o_grant_mask(gm1), .o_count(cnt1)
    );

    issue_multi_select #(.SIZE(16), .NUM_GRANTS(4)) dut2 (
        .clk(clk), .rstn(rstn), .i_flush(flush), .i_stall(stall),
        .i_req_mask(req2), .o_valid(v2), .o_idx(idx2),
        .o_grant_mask(gm2), .o_count(cnt2)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input int ev0, input int ei0, input int ev1,
                        input int ei1, input int ecnt, input int emask);
        cmp({tag, "_v0"},   32'(v1[0]),   32'(ev0));
        cmp({tag, "_i0"},   32'(idx1[0]), 32'(ei0));
        cmp({tag, "_v1"},   32'(v1[1]),   32'(ev1));
        cmp({tag, "_i1"},   32'(idx1[1]), 32'(ei1));
        cmp({tag, "_cnt"},  32'(cnt1),    32'(ecnt));
        cmp({tag, "_mask"}, 32'(gm1),     32'(emask));
    endtask

    task automatic chk2(input string tag, input int ev [4], input int ei [4],
                        input int ecnt, input int emask);
        for (int g = 0; g < 4; g++) begin
            cmp($sformatf("%s_v%0d", tag, g), 32'(v2[g]),   32'(ev[g]));
            cmp($sformatf("%s_i%0d", tag, g), 32'(idx2[g]), 32'(ei[g]));
        end
        cmp({tag, "_cnt"},  32'(cnt2), 32'(ecnt));
        cmp({tag, "_mask"}, 32'(gm2),  32'(emask));
    endtask

    task automatic set_req1(input logic [15:0] m);
        for (int i = 0; i < 16; i++) req1[i] = m[i];
    endtask

    task automatic set_req2(input logic [15:0] m);
        for (int i = 0; i < 16; i++) req2[i] = m[i];
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn  = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        set_req1(16'h0000);
        set_req2(16'h0000);

        // Reset state
        #12;
        chk1("reset", 0, 0, 0, 0, 0, 16'h0000);
        chk2("reset2", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 16'h0000);
        rstn = 1'b1;

        // Requests {3,7,9}: two lowest from ptr 0; dut2 sees only {13}
        set_req1(16'h0288);
        set_req2(16'h2000);
        step();
        chk1("first", 1, 3, 1, 7, 2, 16'h0088);
        chk2("n4_single", '{1, 0, 0, 0}, '{13, 0, 0, 0}, 1, 16'h2000);

        // Held requests: 3 and 7 masked, only 9 left; dut2 all set
        set_req2(16'hFFFF);
        step();
        chk1("masked", 1, 9, 0, 0, 1, 16'h0200);
        if (RR) chk2("n4_wrap", '{1, 1, 1, 1}, '{14, 15, 0, 1}, 4, 16'hC003);
        else    chk2("n4_wrap", '{1, 1, 1, 1}, '{0, 1, 2, 3}, 4, 16'h000F);

        // Held again: 9 masked, 3 and 7 eligible again
        set_req2(16'h0000);
        step();
        chk1("regrant", 1, 3, 1, 7, 2, 16'h0088);
        chk2("n4_idle", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 16'h0000);

        // No requests
        set_req1(16'h0000);
        step();
        chk1("idle", 0, 0, 0, 0, 0, 16'h0000);

        // Single request 14 (moves rotating pointer to 15)
        set_req1(16'h4000);
        step();
        chk1("single14", 1, 14, 0, 0, 1, 16'h4000);

        // Requests {0,15}: wrap-around order vs fixed priority
        set_req1(16'h8001);
        step();
        chk1("wrap", 1, RR ? 15 : 0, 1, RR ? 0 : 15, 2, 16'h8001);

        // Idle cycle, pointer held
        set_req1(16'h0000);
        step();
        chk1("idle2", 0, 0, 0, 0, 0, 16'h0000);

        // Requests {0,5}: rotating pointer sits at 1 after the wrap grant
        set_req1(16'h0021);
        step();
        chk1("ptr1", 1, RR ? 5 : 0, 1, RR ? 0 : 5, 2, 16'h0021);

        // Requests {2,4,6}
        set_req1(16'h0054);
        step();
        chk1("pre_stall", 1, 2, 1, 4, 2, 16'h0014);

        // Stall for three cycles while requests change: everything holds
        stall = 1'b1;
        set_req1(16'h0003);
        step();
        chk1("stall_a", 1, 2, 1, 4, 2, 16'h0014);
        set_req1(16'h0100);
        step();
        chk1("stall_b", 1, 2, 1, 4, 2, 16'h0014);
        set_req1(16'hFFFF);
        step();
        chk1("stall_c", 1, 2, 1, 4, 2, 16'h0014);

        // Flush together with stall: flush wins
        flush = 1'b1;
        step();
        chk1("flush", 0, 0, 0, 0, 0, 16'h0000);

        // Resume with {2,4,6}: pointer (5) survived stall and flush
        flush = 1'b0;
        stall = 1'b0;
        set_req1(16'h0054);
        step();
        chk1("post_flush", 1, RR ? 6 : 2, 1, RR ? 2 : 4, 2, RR ? 16'h0044 : 16'h0014);

        // Asynchronous reset between clock edges
        #3;
        rstn = 1'b0;
        #1;
        chk1("async_rst", 0, 0, 0, 0, 0, 16'h0000);
        #1;
        rstn = 1'b1;

        // After reset the pointer is 0 again: {1,9} grant 1 then 9
        set_req1(16'h0202);
        step();
        chk1("post_rst", 1, 1, 1, 9, 2, 16'h0202);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_multi_select.md
ISSUE_MULTI_SELECT -- requirements
Module: issue_multi_select

Interface
REQ-001 SHALL have parameter SIZE, default 16, number of request entries (power of 2, >=2).
REQ-002 SHALL have parameter NUM_GRANTS, default 2, maximum grants per cycle (1..SIZE).
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port i_stall  input  1  downstream not ready; hold outputs.
REQ-007 SHALL have port i_req_mask  input  unpacked [SIZE] x 1  per-entry ready request.
REQ-008 SHALL have port o_valid  output  unpacked [NUM_GRANTS] x 1  grant slot g is valid.
REQ-009 SHALL have port o_idx  output  unpacked [NUM_GRANTS] x $clog2(SIZE)  granted entry index per slot.
REQ-010 SHALL have port o_grant_mask  output  SIZE  one-hot-per-grant mask of the entries currently granted.
REQ-011 SHALL have port o_count  output  $clog2(NUM_GRANTS+1)  number of valid slots.

Function
REQ-012 SHALL compute eligible = i_req_mask & ~o_grant_mask each cycle, so an entry granted in the previous cycle is never re-granted while its request is still high.
REQ-013 SHALL scan eligible in priority order starting at pointer ptr, ascending and wrapping mod SIZE, and pick the first up to NUM_GRANTS set entries.
REQ-014 SHALL place the k-th picked entry in slot k: o_valid[k]=1, o_idx[k]=index. Unused slots get o_valid=0 and o_idx=0.
REQ-015 SHALL register all outputs, giving a latency of exactly 1 cycle from i_req_mask to grant.
REQ-016 SHALL keep o_grant_mask equal to the OR of one-hot(o_idx[k]) over all valid slots. o_count SHALL equal popcount(o_valid).
REQ-017 When i_stall=1 and i_flush=0, SHALL hold all outputs and ptr unchanged and perform no new selection.
REQ-018 When i_stall=0 and at least one grant is made, SHALL update ptr to (index of last granted entry + 1) mod SIZE on the same edge.
REQ-019 When no eligible entry exists, SHALL clear all o_valid, o_grant_mask and o_count, and hold ptr.
REQ-020 When i_flush=1, SHALL clear o_valid, o_idx, o_grant_mask and o_count on the next edge regardless of i_stall (flush wins), and preserve ptr.
REQ-021 Wrap-around: with ptr=SIZE-1 and entries SIZE-1 and 0 eligible, SHALL grant SIZE-1 in slot 0 and 0 in slot 1.
REQ-022 Fewer eligible entries than NUM_GRANTS: SHALL grant all of them in priority order, with no duplicates.

Reset
REQ-023 SHALL, while rstn=0, asynchronously force o_valid=0, o_idx=0, o_grant_mask=0, o_count=0 and ptr=0.
REQ-024 SHALL resume selection on the first rising clk edge after rstn deasserts. Reset asserted mid-operation SHALL discard any held grants.

Configuration
REQ-025 With macro ISSUE_MULTI_SELECT_RR_EN defined, SHALL implement the rotating pointer per REQ-013/REQ-018.
REQ-026 Without ISSUE_MULTI_SELECT_RR_EN, SHALL have no ptr register, fix priority at lowest index first (ptr constant 0), and otherwise behave identically.

Verification
REQ-027 SIZE=16, NUM_GRANTS=2, RR on, reset, req bits {3,7,9} -> next cycle slot0=3, slot1=7, o_count=2, o_grant_mask=0x0088, ptr=8.
REQ-028 Same bench, req {3,7,9} held one more cycle -> slot0=9 only (3,7 masked), o_count=1, ptr=10.
REQ-029 ptr=15, req {0,15} -> slot0=15, slot1=0, ptr=1. With macro undefined -> slot0=0, slot1=15.
REQ-030 Grants valid, i_stall=1 for 3 cycles while req changes -> outputs and ptr unchanged. Then i_stall=1 together with i_flush=1 -> o_valid=0, o_grant_mask=0 next cycle.
REQ-031 req=0 -> all o_valid=0, o_count=0, ptr held. rstn pulsed low mid-cycle -> outputs zero immediately, without waiting for clk.
REQ-032 NUM_GRANTS=4, req all 16 set, ptr=14 -> slots 14,15,0,1, o_count=4, ptr=2.
